multicycle_control_unit: RTL

Parametrised multi-cycle control unit for the teaching processor, replacing the combinational instruction-field decoder. It owns the instruction register and the step counter, which was previously supplied from outside. It drives every datapath enable, one-hot per register, for each step of each instruction. Register count and instruction width are set by parameters.

---
 rtl/multicycle_control_unit_pkg.sv | 34 +++
 rtl/multicycle_control_unit_onehot_reg_decoder.sv | 15 +
 rtl/multicycle_control_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the teaching processor: opcodes, control steps and ALU
// operation encodings. The datapath and ALU import the same definitions.
package multicycle_control_unit_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_RSV0 = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_RSV1 = 3'b110;
  localparam logic [2:0] OP_MV   = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;

  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_NAND: return ALU_NAND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_onehot_reg_decoder.sv
// Register-index to one-hot enable decoder; all zeros when not enabled.
module onehot_reg_decoder #(
  parameter int RW = 3
) (
  input  logic              en_i,
  input  logic [RW-1:0]     idx_i,
  output logic [2**RW-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: owns the instruction register and step counter and
// decodes every datapath enable from the current step and instruction.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter  int IW   = 16,
  parameter  int OPW  = 3,
  parameter  int RW   = 3,
  localparam int NREG = 2**RW,
  localparam int IMMW = IW - OPW - RW
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IW-1:0]   DIN,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            ImmOut,
  output logic [1:0]      AluOp,
  output logic            OutEn,
  output logic [IMMW-1:0] Imediato,
  output logic [1:0]      Step,
  output logic            Done
);

  step_e          step_q, step_d;
  logic [IW-1:0]  ir_q;
  logic [OPW-1:0] op;
  logic [RW-1:0]  rx, ry;
  logic           fetch;
  logic           rin_en, rout_en;
  logic [RW-1:0]  rout_sel;

  assign op       = ir_q[IW-1 -: OPW];
  assign rx       = ir_q[IW-OPW-1 -: RW];
  assign ry       = ir_q[IW-OPW-RW-1 -: RW];
  assign Imediato = ir_q[IMMW-1:0];
  assign Step     = step_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      if (fetch) ir_q <= DIN;
    end
  end

  always_comb begin
    step_d   = step_q;
    fetch    = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = rx;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    ImmOut   = 1'b0;
    AluOp    = ALU_ADD;
    OutEn    = 1'b0;
    Done     = 1'b0;
    case (step_q)
      T0: begin
        if (Run) begin
          fetch  = 1'b1;
          step_d = T1;
        end
      end
      T1: begin
        step_d = T0;
        case (op)
          OP_ADD, OP_SUB, OP_NAND: begin
            rout_en = 1'b1;
            Ain     = 1'b1;
            step_d  = T2;
          end
          OP_MV: begin
            rout_en  = 1'b1;
            rout_sel = ry;
            rin_en   = 1'b1;
            Done     = 1'b1;
          end
          OP_LDI: begin
            ImmOut = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          OP_OUT: begin
            rout_en = 1'b1;
            OutEn   = 1'b1;
            Done    = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        rout_en  = 1'b1;
        rout_sel = ry;
        Gin      = 1'b1;
        AluOp    = alu_op_of(op);
        step_d   = T3;
      end
      T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
  end

  // Run is combinational into IRin, so gate it to keep outputs quiet in reset.
  assign IRin = fetch & Resetn;

  onehot_reg_decoder #(.RW(RW)) u_rin_dec (
    .en_i     (rin_en),
    .idx_i    (rx),
    .onehot_o (Rin)
  );

  onehot_reg_decoder #(.RW(RW)) u_rout_dec (
    .en_i     (rout_en),
    .idx_i    (rout_sel),
    .onehot_o (Rout)
  );

endmodule
